// File: rtl/store_port_arbiter_pkg.sv
// Shared definitions for the data-memory store port: opcodes, error codes,
// big-endian lane ordering and the arbiter FSM state type.
package store_port_arbiter_pkg;

   localparam logic [5:0] OP_SB = 6'h28;
   localparam logic [5:0] OP_SH = 6'h29;
   localparam logic [5:0] OP_SW = 6'h2B;

   localparam logic [1:0] ERR_NONE       = 2'b00;
   localparam logic [1:0] ERR_MISALIGNED = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL    = 2'b10;

   // Big-endian: byte offset 0 lives in lane 3 (bits 31:24).
   localparam logic [3:0] LANE_BYTE_OFS0 = 4'b1000;
   localparam logic [3:0] LANE_HALF_OFS0 = 4'b1100;
   localparam logic [3:0] LANE_WORD      = 4'b1111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } arb_state_e;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational store formatter: opcode + byte offset + data -> byte-lane
// enables, lane-replicated data and alignment/opcode legality flags.
module store_lane_gen
   import store_port_arbiter_pkg::*;
(
   input  logic [5:0]  opcode_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] data_i,
   output logic [3:0]  we_o,
   output logic [31:0] din_o,
   output logic        misaligned_o,
   output logic        illegal_o
);

   always_comb begin
      we_o         = 4'b0000;
      din_o        = 32'h0;
      misaligned_o = 1'b0;
      illegal_o    = 1'b0;
      case (opcode_i)
         OP_SB: begin
            we_o  = LANE_BYTE_OFS0 >> offset_i;
            din_o = {4{data_i[7:0]}};
         end
         OP_SH: begin
            if (offset_i[0]) begin
               misaligned_o = 1'b1;
            end else begin
               we_o  = LANE_HALF_OFS0 >> offset_i;
               din_o = {2{data_i[15:0]}};
            end
         end
         OP_SW: begin
            if (offset_i != 2'b00) begin
               misaligned_o = 1'b1;
            end else begin
               we_o  = LANE_WORD;
               din_o = data_i;
            end
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/store_port_arbiter.sv
// Round-robin arbiter sharing the data-memory write port between the CPU
// MEM stage (requester 0) and the debug loader (requester 1).
module store_port_arbiter
   import store_port_arbiter_pkg::*;
#(
   parameter int   ADDR_W        = 12,
   parameter logic ARB_RESET_PRI = 1'b0
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [5:0]        req0_opcode,
   input  logic [31:0]       req0_addr,
   input  logic [31:0]       req0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [5:0]        req1_opcode,
   input  logic [31:0]       req1_addr,
   input  logic [31:0]       req1_data,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   input  logic              mem_ack,
   output logic              err_valid,
   output logic [1:0]        err_code,
   output logic              err_src
);

   arb_state_e        state_q, state_d;
   logic              last_grant_q;
   logic              gnt_valid;
   logic              gnt_sel;

   logic              mem_en_q;
   logic [3:0]        mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_din_q;
   logic              err_valid_q;
   logic [1:0]        err_code_q;
   logic              err_src_q;

   logic [5:0]        sel_opcode;
   logic [31:0]       sel_addr;
   logic [31:0]       sel_data;
   logic [3:0]        lg_we;
   logic [31:0]       lg_din;
   logic              lg_misaligned;
   logic              lg_illegal;
   logic              lg_bad;
   logic              addr_hi_unused;

   assign sel_opcode = gnt_sel ? req1_opcode : req0_opcode;
   assign sel_addr   = gnt_sel ? req1_addr   : req0_addr;
   assign sel_data   = gnt_sel ? req1_data   : req0_data;

   store_lane_gen u_lane_gen (
      .opcode_i     (sel_opcode),
      .offset_i     (sel_addr[1:0]),
      .data_i       (sel_data),
      .we_o         (lg_we),
      .din_o        (lg_din),
      .misaligned_o (lg_misaligned),
      .illegal_o    (lg_illegal)
   );

   assign lg_bad         = lg_misaligned | lg_illegal;
   assign addr_hi_unused = ^sel_addr[31:ADDR_W+2];

   // Grant and ready are purely combinational and only exist in IDLE.
   always_comb begin
      state_d    = state_q;
      gnt_valid  = 1'b0;
      gnt_sel    = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req0_valid && req1_valid) begin
               gnt_valid = 1'b1;
               gnt_sel   = ~last_grant_q;
            end else if (req0_valid) begin
               gnt_valid = 1'b1;
               gnt_sel   = 1'b0;
            end else if (req1_valid) begin
               gnt_valid = 1'b1;
               gnt_sel   = 1'b1;
            end
            req0_ready = gnt_valid & ~gnt_sel;
            req1_ready = gnt_valid &  gnt_sel;
            if (gnt_valid && !lg_bad) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (mem_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= ~ARB_RESET_PRI;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 4'b0000;
         mem_addr_q   <= '0;
         mem_din_q    <= 32'h0;
         err_valid_q  <= 1'b0;
         err_code_q   <= ERR_NONE;
         err_src_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_valid_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         err_src_q   <= 1'b0;
         if (gnt_valid) begin
            last_grant_q <= gnt_sel;
            if (lg_bad) begin
               // A rejected store is consumed here; it never reaches memory.
               err_valid_q <= 1'b1;
               err_code_q  <= lg_illegal ? ERR_ILLEGAL : ERR_MISALIGNED;
               err_src_q   <= gnt_sel;
            end else begin
               mem_en_q   <= 1'b1;
               mem_we_q   <= lg_we;
               mem_addr_q <= sel_addr[ADDR_W+1:2];
               mem_din_q  <= lg_din;
            end
         end else if (state_q == ST_ISSUE && mem_ack) begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 4'b0000;
            mem_addr_q <= '0;
            mem_din_q  <= 32'h0;
         end
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign err_src   = err_src_q;

endmodule

// File: tb/tb_store_port_arbiter.sv
// Directed bench for store_port_arbiter: vector table plus hand sequences
// for hold-until-ack, contention, back-to-back errors and mid-issue reset.
module tb_store_port_arbiter;

   localparam int   ADDR_W = 12;
   localparam logic PRI    = 1'b0;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req0_valid, req1_valid;
   logic              req0_ready, req1_ready;
   logic [5:0]        req0_opcode, req1_opcode;
   logic [31:0]       req0_addr, req1_addr, req0_data, req1_data;
   logic              mem_en, mem_ack;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic              err_valid, err_src;
   logic [1:0]        err_code;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_port_arbiter #(.ADDR_W(ADDR_W), .ARB_RESET_PRI(PRI)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_opcode (req0_opcode),
      .req0_addr   (req0_addr),
      .req0_data   (req0_data),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_opcode (req1_opcode),
      .req1_addr   (req1_addr),
      .req1_data   (req1_data),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_din     (mem_din),
      .mem_ack     (mem_ack),
      .err_valid   (err_valid),
      .err_code    (err_code),
      .err_src     (err_src)
   );

   typedef struct {
      string       name;
      logic        v0, v1;
      logic [5:0]  op;
      logic [31:0] addr, data;
      logic        r0, r1;
      logic        en;
      logic [3:0]  we;
      logic [31:0] maddr, din;
      logic        ev;
      logic [1:0]  code;
      logic        src;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input string n, input logic v0, input logic v1, input logic [5:0] op,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                      input logic [31:0] ma, input logic [31:0] din, input logic ev,
                      input logic [1:0] code);
      vec_t v;
      v.name = n; v.v0 = v0; v.v1 = v1; v.op = op; v.addr = a; v.data = d;
      v.r0 = v0; v.r1 = v1; v.en = !ev; v.we = we; v.maddr = ma; v.din = din;
      v.ev = ev; v.code = code; v.src = v1;
      vecs.push_back(v);
   endtask

   task automatic run_vec(input vec_t v);
      req0_valid = v.v0; req0_opcode = v.op; req0_addr = v.addr; req0_data = v.data;
      req1_valid = v.v1; req1_opcode = v.op; req1_addr = v.addr; req1_data = v.data;
      #1;
      check({v.name, ".ready0"}, {31'b0, req0_ready}, {31'b0, v.r0});
      check({v.name, ".ready1"}, {31'b0, req1_ready}, {31'b0, v.r1});
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      check({v.name, ".mem_en"},    {31'b0, mem_en},    {31'b0, v.en});
      check({v.name, ".mem_we"},    {28'b0, mem_we},    {28'b0, v.we});
      check({v.name, ".mem_addr"},  {20'b0, mem_addr},  v.maddr);
      check({v.name, ".mem_din"},   mem_din,            v.din);
      check({v.name, ".err_valid"}, {31'b0, err_valid}, {31'b0, v.ev});
      check({v.name, ".err_code"},  {30'b0, err_code},  {30'b0, v.code});
      check({v.name, ".err_src"},   {31'b0, err_src},   {31'b0, v.ev & v.src});
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      #1;
      check({v.name, ".en_after"},  {31'b0, mem_en},    32'd0);
      check({v.name, ".err_after"}, {31'b0, err_valid}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; mem_ack = 1'b0;
      req0_valid = 1'b0; req0_opcode = '0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_opcode = '0; req1_addr = '0; req1_data = '0;

      add("sw_basic", 1, 0, 6'h2B, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h004, 32'hDEAD_BEEF, 0, 2'b00);
      add("sb_ofs0",  0, 1, 6'h28, 32'h0000_0100, 32'h0000_00A5, 4'b1000, 32'h040, 32'hA5A5_A5A5, 0, 2'b00);
      add("sb_ofs1",  0, 1, 6'h28, 32'h0000_0101, 32'h0000_00A5, 4'b0100, 32'h040, 32'hA5A5_A5A5, 0, 2'b00);
      add("sb_ofs2",  0, 1, 6'h28, 32'h0000_0102, 32'h0000_00A5, 4'b0010, 32'h040, 32'hA5A5_A5A5, 0, 2'b00);
      add("sb_ofs3",  0, 1, 6'h28, 32'h0000_0103, 32'h0000_00A5, 4'b0001, 32'h040, 32'hA5A5_A5A5, 0, 2'b00);
      add("sh_ofs2",  0, 1, 6'h29, 32'h0000_0022, 32'h0000_1234, 4'b0011, 32'h008, 32'h1234_1234, 0, 2'b00);
      add("sh_ofs0",  1, 0, 6'h29, 32'h0000_0044, 32'hABCD_5678, 4'b1100, 32'h011, 32'h5678_5678, 0, 2'b00);
      add("sh_mis",   0, 1, 6'h29, 32'h0000_0021, 32'h0000_1234, 4'b0000, 32'h000, 32'h0000_0000, 1, 2'b01);
      add("sw_mis",   1, 0, 6'h2B, 32'h0000_0012, 32'h1111_2222, 4'b0000, 32'h000, 32'h0000_0000, 1, 2'b01);
      add("illegal",  1, 0, 6'h23, 32'h0000_0030, 32'h5555_AAAA, 4'b0000, 32'h000, 32'h0000_0000, 1, 2'b10);
      add("sb_top",   1, 0, 6'h28, 32'hFFFF_FFFD, 32'h1234_567E, 4'b0100, 32'hFFF, 32'h7E7E_7E7E, 0, 2'b00);

      // Reset state
      tick(); tick();
      check("rst.mem_en",    {31'b0, mem_en},    32'd0);
      check("rst.mem_we",    {28'b0, mem_we},    32'd0);
      check("rst.mem_addr",  {20'b0, mem_addr},  32'd0);
      check("rst.mem_din",   mem_din,            32'd0);
      check("rst.err_valid", {31'b0, err_valid}, 32'd0);
      check("rst.err_code",  {30'b0, err_code},  32'd0);
      rst_n = 1'b1;
      tick();

      // Contention with immediate acks: grants alternate starting at PRI
      req0_valid = 1; req0_opcode = 6'h2B; req0_addr = 32'h100; req0_data = 32'h1111_1111;
      req1_valid = 1; req1_opcode = 6'h2B; req1_addr = 32'h200; req1_data = 32'h2222_2222;
      mem_ack = 1'b1;
      #1;
      for (int g = 0; g < 4; g++) begin
         logic exp_sel;
         exp_sel = PRI ^ g[0];
         check($sformatf("cont%0d.ready0", g), {31'b0, req0_ready}, {31'b0, ~exp_sel});
         check($sformatf("cont%0d.ready1", g), {31'b0, req1_ready}, {31'b0, exp_sel});
         tick();
         check($sformatf("cont%0d.issue_rdy", g), {30'b0, req1_ready, req0_ready}, 32'd0);
         check($sformatf("cont%0d.mem_en", g), {31'b0, mem_en}, 32'd1);
         check($sformatf("cont%0d.mem_addr", g), {20'b0, mem_addr}, exp_sel ? 32'h080 : 32'h040);
         tick();
      end
      req0_valid = 0; req1_valid = 0; mem_ack = 1'b0;
      #1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // SW held for 3 cycles until ack; a competing request is refused meanwhile
      req0_valid = 1; req0_opcode = 6'h2B; req0_addr = 32'h10; req0_data = 32'hDEAD_BEEF;
      tick();
      req0_valid = 0;
      req1_valid = 1; req1_opcode = 6'h28; req1_addr = 32'h3; req1_data = 32'h77;
      #1;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("hold%0d.mem_en", c),   {31'b0, mem_en},     32'd1);
         check($sformatf("hold%0d.mem_we", c),   {28'b0, mem_we},     32'hF);
         check($sformatf("hold%0d.mem_addr", c), {20'b0, mem_addr},   32'h004);
         check($sformatf("hold%0d.mem_din", c),  mem_din,             32'hDEAD_BEEF);
         check($sformatf("hold%0d.ready1", c),   {31'b0, req1_ready}, 32'd0);
         if (c == 2) begin
            mem_ack = 1'b1; req1_valid = 1'b0;
         end
         tick();
      end
      mem_ack = 1'b0;
      #1;
      check("hold.en_after", {31'b0, mem_en}, 32'd0);

      // Back-to-back illegal requests give consecutive error pulses
      req0_valid = 1; req0_opcode = 6'h23; req0_addr = 32'h0;
      tick();
      check("b2b.err1",   {31'b0, err_valid},  32'd1);
      check("b2b.ready",  {31'b0, req0_ready}, 32'd1);
      tick();
      req0_valid = 0;
      #1;
      check("b2b.err2",   {31'b0, err_valid}, 32'd1);
      check("b2b.code2",  {30'b0, err_code},  32'd2);
      check("b2b.no_mem", {31'b0, mem_en},    32'd0);
      tick();
      check("b2b.err_end", {31'b0, err_valid}, 32'd0);

      // Reset mid-ISSUE after a requester-0 grant, then a tie goes to PRI
      req0_valid = 1; req0_opcode = 6'h2B; req0_addr = 32'h20; req0_data = 32'hCAFE_F00D;
      tick();
      req0_valid = 0;
      #1;
      check("rmid.mem_en", {31'b0, mem_en}, 32'd1);
      rst_n = 1'b0;
      tick();
      check("rmid.en_rst",  {31'b0, mem_en},    32'd0);
      check("rmid.err_rst", {31'b0, err_valid}, 32'd0);
      rst_n = 1'b1;
      req0_valid = 1; req0_opcode = 6'h2B; req0_addr = 32'h100; req0_data = 32'h1111_1111;
      req1_valid = 1; req1_opcode = 6'h2B; req1_addr = 32'h200; req1_data = 32'h2222_2222;
      #1;
      check("rmid.tie_r0", {31'b0, req0_ready}, {31'b0, ~PRI});
      check("rmid.tie_r1", {31'b0, req1_ready}, {31'b0, PRI});
      tick();
      req0_valid = 0; req1_valid = 0;
      #1;
      check("rmid.svc_en",   {31'b0, mem_en},   32'd1);
      check("rmid.svc_addr", {20'b0, mem_addr}, PRI ? 32'h080 : 32'h040);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      #1;
      check("rmid.svc_done", {31'b0, mem_en}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
